// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction selectors and code helper,
// Capture-IR pattern and the 1149.1 next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    SEL_IDCODE = 2'd0,
    SEL_USER   = 2'd1,
    SEL_BYPASS = 2'd2
  } instr_sel_t;

  localparam logic [1:0] CAPTURE_IR_PATTERN = 2'b01;
  localparam int unsigned IDCODE_WIDTH = 32;

  function automatic logic [31:0] instr_code(input int unsigned width, input instr_sel_t which);
    logic [31:0] code;
    case (which)
      SEL_IDCODE: code = 32'd1;
      SEL_USER:   code = 32'd2;
      SEL_BYPASS: code = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      default:    code = 32'd1;
    endcase
    return code;
  endfunction

  function automatic tap_state_t tap_next(input tap_state_t cur, input logic tms);
    tap_state_t nxt;
    case (cur)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          nxt = TEST_LOGIC_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Multi-stage synchroniser for the JTAG pins plus tck edge detection.
// With JTAG_TRST_EN defined, trst_n rides the same synchroniser.
module jtag_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
`ifdef JTAG_TRST_EN
  input  logic trst_n,
  output logic trst_n_s,
`endif
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

`ifdef JTAG_TRST_EN
  localparam int PINS = 4;
`else
  localparam int PINS = 3;
`endif

  logic [PINS-1:0]                  pins_s;
  logic [SYNC_STAGES-1:0][PINS-1:0] sync_q;
  logic [PINS-1:0]                  last_s;
  logic                             tck_prev_q;

`ifdef JTAG_TRST_EN
  assign pins_s   = {trst_n, tdi, tms, tck};
  assign trst_n_s = last_s[3];
`else
  assign pins_s   = {tdi, tms, tck};
`endif

  // All pins share one chain so tms/tdi stay aligned with the tck sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pins_s};
      tck_prev_q <= sync_q[SYNC_STAGES-1][0];
    end
  end

  assign last_s   = sync_q[SYNC_STAGES-1];
  assign tck_rise = last_s[0] & ~tck_prev_q;
  assign tck_fall = ~last_s[0] & tck_prev_q;
  assign tms_s    = last_s[1];
  assign tdi_s    = last_s[2];

endmodule

// File: rtl/jtag_tap_sync.sv
// IEEE 1149.1 TAP controller oversampled in the clk domain, with IDCODE, BYPASS
// and a USER data register. Optional macro JTAG_TRST_EN adds the trst_n pin.
module jtag_tap_sync
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1BEEF0FF,
  parameter int          USER_DR_WIDTH = 8,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tck,
  input  logic                     tms,
  input  logic                     tdi,
`ifdef JTAG_TRST_EN
  input  logic                     trst_n,
`endif
  output logic                     tdo,
  output logic                     tdo_oe,
  output logic [3:0]               tap_state,
  output logic [IR_WIDTH-1:0]      ir_value,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_update
);

  localparam logic [IR_WIDTH-1:0] INSTR_IDCODE     = IR_WIDTH'(instr_code(IR_WIDTH, SEL_IDCODE));
  localparam logic [IR_WIDTH-1:0] INSTR_USER       = IR_WIDTH'(instr_code(IR_WIDTH, SEL_USER));
  localparam logic [IR_WIDTH-1:0] INSTR_BYPASS     = IR_WIDTH'(instr_code(IR_WIDTH, SEL_BYPASS));
  localparam logic [IR_WIDTH-1:0] CAPTURE_IR_VALUE = IR_WIDTH'(CAPTURE_IR_PATTERN);

  logic tck_rise_s;
  logic tck_fall_s;
  logic tms_s;
  logic tdi_s;
  logic trst_force_s;

  tap_state_t                 state_q;
  tap_state_t                 state_d;
  logic [IR_WIDTH-1:0]        ir_q;
  logic [IR_WIDTH-1:0]        ir_sr_q;
  logic [IDCODE_WIDTH-1:0]    idcode_sr_q;
  logic [USER_DR_WIDTH-1:0]   user_sr_q;
  logic                       bypass_q;
  logic                       tdo_q;
  logic                       tdo_oe_q;
  logic [USER_DR_WIDTH-1:0]   user_out_q;
  logic                       user_update_q;

  logic sel_idcode_s;
  logic sel_user_s;
  logic dr_lsb_s;

`ifdef JTAG_TRST_EN
  logic trst_n_s;

  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .trst_n   (trst_n),
    .trst_n_s (trst_n_s),
    .tck_rise (tck_rise_s),
    .tck_fall (tck_fall_s),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  assign trst_force_s = ~trst_n_s;
`else
  jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tck_rise (tck_rise_s),
    .tck_fall (tck_fall_s),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  assign trst_force_s = 1'b0;
`endif

  // Anything other than IDCODE or USER (BYPASS included) routes to the bypass bit.
  assign sel_idcode_s = (ir_q == INSTR_IDCODE);
  assign sel_user_s   = (ir_q == INSTR_USER) && (ir_q != INSTR_BYPASS);
  assign state_d      = tap_next(state_q, tms_s);

  // LSB of whichever data register the current instruction selects.
  always_comb begin
    dr_lsb_s = bypass_q;
    if (sel_idcode_s) begin
      dr_lsb_s = idcode_sr_q[0];
    end else if (sel_user_s) begin
      dr_lsb_s = user_sr_q[0];
    end else begin
      dr_lsb_s = bypass_q;
    end
  end

  // TAP state machine, shift registers and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= TEST_LOGIC_RESET;
      ir_q          <= INSTR_IDCODE;
      ir_sr_q       <= '0;
      idcode_sr_q   <= '0;
      user_sr_q     <= '0;
      bypass_q      <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
      user_out_q    <= '0;
      user_update_q <= 1'b0;
    end else if (trst_force_s) begin
      state_q       <= TEST_LOGIC_RESET;
      ir_q          <= INSTR_IDCODE;
      user_update_q <= 1'b0;
    end else begin
      user_update_q <= 1'b0;
      if (tck_rise_s) begin
        state_q <= state_d;
        case (state_q)
          CAPTURE_IR: ir_sr_q <= CAPTURE_IR_VALUE;
          SHIFT_IR:   ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
          UPDATE_IR:  ir_q    <= ir_sr_q;
          CAPTURE_DR: begin
            if (sel_idcode_s) begin
              idcode_sr_q <= IDCODE_VALUE;
            end else if (sel_user_s) begin
              user_sr_q <= user_dr_in;
            end else begin
              bypass_q <= 1'b0;
            end
          end
          SHIFT_DR: begin
            if (sel_idcode_s) begin
              idcode_sr_q <= {tdi_s, idcode_sr_q[IDCODE_WIDTH-1:1]};
            end else if (sel_user_s) begin
              user_sr_q <= (user_sr_q >> 1) | (USER_DR_WIDTH'(tdi_s) << (USER_DR_WIDTH - 1));
            end else begin
              bypass_q <= tdi_s;
            end
          end
          UPDATE_DR: begin
            if (sel_user_s) begin
              user_out_q    <= user_sr_q;
              user_update_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
        if (state_d == TEST_LOGIC_RESET) begin
          ir_q <= INSTR_IDCODE;
        end
      end
      // tdo_oe drops on the first falling edge seen outside a shift state.
      if (tck_fall_s) begin
        if (state_q == SHIFT_IR) begin
          tdo_q    <= ir_sr_q[0];
          tdo_oe_q <= 1'b1;
        end else if (state_q == SHIFT_DR) begin
          tdo_q    <= dr_lsb_s;
          tdo_oe_q <= 1'b1;
        end else begin
          tdo_oe_q <= 1'b0;
        end
      end
    end
  end

  assign tdo         = tdo_q;
  assign tdo_oe      = tdo_oe_q;
  assign tap_state   = state_q;
  assign ir_value    = ir_q;
  assign user_dr_out = user_out_q;
  assign user_update = user_update_q;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Directed bench for jtag_tap_sync: pin-level tck driving, a state-graph/register
// model updated at each pin edge, and a per-clk compare against that model.
`timescale 1ns/1ps
module tb_jtag_tap_sync;
  import jtag_pkg::*;

  localparam int          IRW = 4;
  localparam int          UDW = 8;
  localparam int          SS  = 2;
  localparam logic [31:0] IDV = 32'h1BEEF0FF;
  localparam logic [IRW-1:0] C_IDC = 4'h1;
  localparam logic [IRW-1:0] C_USR = 4'h2;

  logic           clk = 1'b0;
  logic           reset;
  logic           tck;
  logic           tms;
  logic           tdi;
  logic           tdo;
  logic           tdo_oe;
  logic [3:0]     tap_state;
  logic [IRW-1:0] ir_value;
  logic [UDW-1:0] user_dr_in;
  logic [UDW-1:0] user_dr_out;
  logic           user_update;
`ifdef JTAG_TRST_EN
  logic           trst_n;
`endif

  jtag_tap_sync #(
    .IR_WIDTH(IRW), .IDCODE_VALUE(IDV), .USER_DR_WIDTH(UDW), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .tck(tck), .tms(tms), .tdi(tdi),
`ifdef JTAG_TRST_EN
    .trst_n(trst_n),
`endif
    .tdo(tdo), .tdo_oe(tdo_oe), .tap_state(tap_state), .ir_value(ir_value),
    .user_dr_in(user_dr_in), .user_dr_out(user_dr_out), .user_update(user_update)
  );

  initial forever #5 clk = ~clk;

  int             n_vec = 0;
  int             n_bad = 0;
  int             pulses = 0;
  bit             mon_en = 1'b0;
  time            last_t = 0;
  logic [3:0]     nxt_tab [16][2];
  logic [3:0]     m_state;
  logic [IRW-1:0] m_ir;
  logic [IRW-1:0] m_ir_sr;
  logic [31:0]    m_dr;
  int             m_w;
  logic           m_tdo;
  logic           m_oe;
  logic [UDW-1:0] m_uout;
  logic           m_upd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_edge(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt_tab[s][0] = n0;
    nxt_tab[s][1] = n1;
  endtask

  task automatic model_reset();
    m_state = TEST_LOGIC_RESET;
    m_ir = C_IDC;
    m_ir_sr = '0;
    m_dr = '0;
    m_w = 1;
    m_tdo = 1'b0;
    m_oe = 1'b0;
    m_uout = '0;
    m_upd = 1'b0;
  endtask

  task automatic model_rise(input logic t, input logic d);
    if (m_state == CAPTURE_IR) begin
      m_ir_sr = IRW'(1);
    end else if (m_state == SHIFT_IR) begin
      m_ir_sr = (m_ir_sr >> 1) | (IRW'(d) << (IRW - 1));
    end else if (m_state == UPDATE_IR) begin
      m_ir = m_ir_sr;
    end else if (m_state == CAPTURE_DR) begin
      if (m_ir == C_IDC) begin m_dr = IDV; m_w = 32; end
      else if (m_ir == C_USR) begin m_dr = 32'(user_dr_in); m_w = UDW; end
      else begin m_dr = '0; m_w = 1; end
    end else if (m_state == SHIFT_DR) begin
      m_dr = (m_dr >> 1) | (32'(d) << (m_w - 1));
    end else if (m_state == UPDATE_DR && m_ir == C_USR) begin
      m_uout = m_dr[UDW-1:0];
      m_upd = 1'b1;
    end
    m_state = nxt_tab[m_state][t];
    if (m_state == TEST_LOGIC_RESET) m_ir = C_IDC;
  endtask

  task automatic model_fall();
    m_upd = 1'b0;
    if (m_state == SHIFT_IR) begin m_tdo = m_ir_sr[0]; m_oe = 1'b1; end
    else if (m_state == SHIFT_DR) begin m_tdo = m_dr[0]; m_oe = 1'b1; end
    else m_oe = 1'b0;
  endtask

  // One tck period (8 clk); o is tdo as seen on the pin just before the rise.
  task automatic tck_cycle(input logic t, input logic d, output logic o);
    @(negedge clk);
    tms = t; tdi = d; o = tdo;
    tck = 1'b1; last_t = $time; model_rise(t, d);
    repeat (4) @(negedge clk);
    tck = 1'b0; last_t = $time; model_fall();
    repeat (3) @(negedge clk);
  endtask

  task automatic walk(input logic [7:0] seq, input int n);
    logic o;
    for (int i = 0; i < n; i++) tck_cycle(seq[i], 1'b0, o);
  endtask

  // From Run-Test/Idle through a full n-bit DR scan back to Run-Test/Idle.
  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    logic o;
    dout = '0;
    walk(8'b001, 3);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], o);
      dout[i] = o;
    end
    walk(8'b01, 2);
  endtask

  task automatic shift_ir(input logic [IRW-1:0] din, output logic [IRW-1:0] dout);
    logic o;
    dout = '0;
    walk(8'b0011, 4);
    for (int i = 0; i < IRW; i++) begin
      tck_cycle(i == IRW - 1, din[i], o);
      dout[i] = o;
    end
    walk(8'b01, 2);
  endtask

  initial begin
    logic [31:0]    d;
    logic [IRW-1:0] ir_out;
    int             p0;
    int             el;
    logic           o;

    set_edge(TEST_LOGIC_RESET, RUN_TEST_IDLE, TEST_LOGIC_RESET);
    set_edge(RUN_TEST_IDLE,    RUN_TEST_IDLE, SELECT_DR_SCAN);
    set_edge(SELECT_DR_SCAN,   CAPTURE_DR,    SELECT_IR_SCAN);
    set_edge(CAPTURE_DR,       SHIFT_DR,      EXIT1_DR);
    set_edge(SHIFT_DR,         SHIFT_DR,      EXIT1_DR);
    set_edge(EXIT1_DR,         PAUSE_DR,      UPDATE_DR);
    set_edge(PAUSE_DR,         PAUSE_DR,      EXIT2_DR);
    set_edge(EXIT2_DR,         SHIFT_DR,      UPDATE_DR);
    set_edge(UPDATE_DR,        RUN_TEST_IDLE, SELECT_DR_SCAN);
    set_edge(SELECT_IR_SCAN,   CAPTURE_IR,    TEST_LOGIC_RESET);
    set_edge(CAPTURE_IR,       SHIFT_IR,      EXIT1_IR);
    set_edge(SHIFT_IR,         SHIFT_IR,      EXIT1_IR);
    set_edge(EXIT1_IR,         PAUSE_IR,      UPDATE_IR);
    set_edge(PAUSE_IR,         PAUSE_IR,      EXIT2_IR);
    set_edge(EXIT2_IR,         SHIFT_IR,      UPDATE_IR);
    set_edge(UPDATE_IR,        RUN_TEST_IDLE, SELECT_DR_SCAN);

    fork
      forever begin
        @(negedge clk);
        if (mon_en && !reset) begin
          if (user_update === 1'b1) pulses++;
          el = int'(($time - last_t) / 10);
          if (el >= SS + 1) begin
            check("tap_state",   32'(tap_state),   32'(m_state));
            check("ir_value",    32'(ir_value),    32'(m_ir));
            check("user_dr_out", 32'(user_dr_out), 32'(m_uout));
            check("tdo",         32'(tdo),         32'(m_tdo));
            check("tdo_oe",      32'(tdo_oe),      32'(m_oe));
          end
          check("user_update", 32'(user_update), 32'(m_upd && (el == SS + 1)));
        end
      end
    join_none

    reset = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; user_dr_in = '0;
`ifdef JTAG_TRST_EN
    trst_n = 1'b1;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_state",  32'(tap_state),   32'hF);
    check("rst_ir",     32'(ir_value),    32'h1);
    check("rst_tdo",    32'(tdo),         32'h0);
    check("rst_oe",     32'(tdo_oe),      32'h0);
    check("rst_uout",   32'(user_dr_out), 32'h0);
    check("rst_update", 32'(user_update), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // IDCODE read straight out of reset
    tck_cycle(1'b0, 1'b0, o);
    check("rti_state", 32'(tap_state), 32'hC);
    shift_dr(32, 32'h0, d);
    check("idcode_out", d, 32'h1BEEF0FF);
    check("oe_after_idcode", 32'(tdo_oe), 32'h0);

    // USER register round trip
    shift_ir(4'h2, ir_out);
    check("capir_out", 32'(ir_out), 32'h1);
    check("ir_user", 32'(ir_value), 32'h2);
    user_dr_in = 8'hA5;
    p0 = pulses;
    shift_dr(8, 32'h3C, d);
    check("user_capture", d & 32'hFF, 32'hA5);
    check("user_dr_out", 32'(user_dr_out), 32'h3C);
    check("user_pulses", 32'(pulses - p0), 32'h1);

    // BYPASS: one-bit delay
    shift_ir(4'hF, ir_out);
    shift_dr(4, 32'b1101, d);
    check("bypass_out", d & 32'hF, 32'b1010);

    // undefined code behaves as bypass
    shift_ir(4'h7, ir_out);
    check("capir_out2", 32'(ir_out), 32'h1);
    check("ir_7", 32'(ir_value), 32'h7);
    shift_dr(3, 32'b011, d);
    check("undef_bypass", d & 32'h7, 32'b110);

    // five tms=1 from Shift-DR
    walk(8'b001, 3);
    walk(8'b11111, 5);
    repeat (4) @(negedge clk);
    check("tms_reset_state", 32'(tap_state), 32'hF);
    check("tms_reset_ir", 32'(ir_value), 32'h1);

    // asynchronous reset in the middle of a USER shift
    tck_cycle(1'b0, 1'b0, o);
    shift_ir(4'h2, ir_out);
    user_dr_in = 8'h5A;
    walk(8'b001, 3);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, o);
    p0 = pulses;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_state", 32'(tap_state),   32'hF);
    check("mid_rst_ir",    32'(ir_value),    32'h1);
    check("mid_rst_uout",  32'(user_dr_out), 32'h0);
    check("mid_rst_oe",    32'(tdo_oe),      32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    walk(8'b011010, 6);
    check("post_rst_uout", 32'(user_dr_out), 32'h0);
    check("post_rst_pulses", 32'(pulses - p0), 32'h0);

`ifdef JTAG_TRST_EN
    // trst_n mid-shift with no tck activity
    shift_ir(4'h2, ir_out);
    walk(8'b001, 3);
    for (int i = 0; i < 2; i++) tck_cycle(1'b0, 1'b1, o);
    p0 = pulses;
    @(negedge clk);
    trst_n = 1'b0;
    m_state = TEST_LOGIC_RESET;
    m_ir = C_IDC;
    last_t = $time;
    repeat (6) @(negedge clk);
    check("trst_state", 32'(tap_state),   32'hF);
    check("trst_ir",    32'(ir_value),    32'h1);
    check("trst_uout",  32'(user_dr_out), 32'h0);
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    walk(8'b11, 2);
    check("trst_pulses", 32'(pulses - p0), 32'h0);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sync.md
Name: jtag_tap_sync

Overview:
Parametrised IEEE 1149.1 TAP controller that runs entirely in the system clk domain. It oversamples tck, tms and tdi through synchronisers and detects tck edges; there is no tck-clocked logic. Instruction width, IDCODE value and user data register width are generalised. It adds a user DR with capture and update strobes so design logic can be accessed over JTAG. It sits between the chip pins and the tt_um top-level user logic.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IDCODE_VALUE, 32'h1BEEF0FF, 32-bit IDCODE; LSB must be 1
USER_DR_WIDTH, 8, width of the USER data register (1..32)
SYNC_STAGES, 2, flop stages on tck/tms/tdi (>=2)

Ports:
clk  in  1  system clock; must be >= 4x tck frequency
reset  in  1  asynchronous, active-high reset
tck  in  1  JTAG clock, asynchronous to clk
tms  in  1  JTAG mode select
tdi  in  1  JTAG data in
tdo  out  1  JTAG data out
tdo_oe  out  1  high while in Shift-DR or Shift-IR
tap_state  out  4  current TAP state, encoded per jtag_pkg
ir_value  out  IR_WIDTH  current instruction
user_dr_in  in  USER_DR_WIDTH  value loaded at Capture-DR when USER is selected
user_dr_out  out  USER_DR_WIDTH  user register, latched at Update-DR when USER is selected
user_update  out  1  one-clk pulse when user_dr_out is updated

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. Port names are clk and reset.
- Reset values: tap_state = TEST_LOGIC_RESET; ir_value = IDCODE instruction; tdo = 0; tdo_oe = 0; user_dr_out = 0; user_update = 0. Synchroniser flops reset to 0.
- Synchronisation and edge detect:
  - tck, tms and tdi each pass through SYNC_STAGES flops.
  - tck_rise and tck_fall are single-clk pulses from the last two synchronised tck samples.
  - tms and tdi are sampled from the same synchronised stage as tck, so they stay aligned.
- FSM: the full 16-state 1149.1 graph. It advances only on tck_rise, using synchronised tms. Five tms=1 rises from any state reach TEST_LOGIC_RESET.
- TEST_LOGIC_RESET: entering it forces ir_value = IDCODE instruction.
- Instruction codes:
  - BYPASS = all ones.
  - IDCODE = 1.
  - USER = 2.
  - Any other code selects bypass.
- Capture actions, on tck_rise while in the capture state:
  - Capture-IR loads the IR shift register with {0..., 2'b01}.
  - Capture-DR loads the selected DR: IDCODE_VALUE, user_dr_in, or 0 for bypass.
- Shift actions, on tck_rise while in the shift state:
  - Shift right, LSB first.
  - tdi enters at the MSB of the selected register; bypass is a 1-bit register.
- Update actions, on tck_rise while in the update state:
  - Update-IR copies the IR shift register to ir_value.
  - Update-DR with USER selected copies the DR shift register to user_dr_out and pulses user_update for exactly one clk.
- tdo: updates on tck_fall to the LSB of the active shift register. It holds its value in all other states.
- tdo_oe: high from the first tck_fall in a Shift state through the first tck_fall after leaving it.
- Latency: an FSM transition becomes visible on tap_state SYNC_STAGES+1 clk after the pin-level tck rise.
- Boundary conditions:
  - tck_rise and tck_fall never coincide; if tck toggles faster than clk/2, behaviour is undefined.
  - Shifting more than the register width keeps shifting; tdi data emerges after width+1 bits.
  - A mid-shift assertion of reset aborts immediately; ir_value and user_dr_out are not updated.

Optional Feature:
Macro JTAG_TRST_EN.
- Defined: adds input trst_n. It passes through the same synchroniser as the other pins; synchronised low forces TEST_LOGIC_RESET and the IDCODE instruction on the next clk, independent of tck.
- Undefined: no trst_n port; TAP reset is only via reset or the tms=1 sequence.

Decomposition:
- Package jtag_pkg:
  - tap_state_t enum of the 16 states (4-bit).
  - Instruction localparams INSTR_IDCODE, INSTR_USER, INSTR_BYPASS, each sized by IR_WIDTH via function instr_code(width, which).
  - Capture-IR pattern constant.
- Sub-module jtag_sync_edge: SYNC_STAGES synchroniser for {tck, tms, tdi}. Outputs tck_rise, tck_fall, tms_s, tdi_s.

Test Plan:
- Reset, then shift 32 DR bits from TEST_LOGIC_RESET via Run-Test/Idle -> tdo stream equals IDCODE_VALUE 32'h1BEEF0FF, LSB first; tdo_oe high only during the shift.
- Load IR=4'h2 (USER), user_dr_in=8'hA5, shift tdi=8'h3C through DR -> tdo yields 8'hA5; at Update-DR user_dr_out=8'h3C and user_update is high for exactly 1 clk.
- Load IR=4'hF (BYPASS), shift 1,0,1,1 -> tdo yields 0 then 1,0,1 (one-bit delay).
- Load IR=4'h7 (undefined code) -> behaves as bypass; Capture-IR shift-out reads 4'b0001.
- From Shift-DR, five tms=1 tck rises -> tap_state = TEST_LOGIC_RESET and ir_value = 4'h1.
- Assert reset during Shift-DR with USER selected -> immediate reset values; user_dr_out stays 0 and there is no user_update pulse. With JTAG_TRST_EN defined: trst_n=0 mid-shift gives the same result with no tck activity.
